sram_port_arbiter: RTL and testbench

- Arbitrates one single-port activation/weight SRAM between two requesters: the AHB slave beat path and the systolic-array operand loader.
- Honours AHB burst locking (burst_active from the AHB burst tracker).
- Guarantees forward progress of the loader through a starvation counter.
- Sits between the AHB slave/burst tracker and the SRAM macro wrapper.

---
 rtl/sram_port_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one single-port activation/weight SRAM between the AHB
//            slave beat path and the systolic-array operand loader. AHB bursts
//            lock the SRAM. The loader is guaranteed forward progress by a
//            starvation counter and is time-sliced against AHB by a quantum.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int MAX_WAIT   = 8,
    parameter int LD_QUANTUM = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    // AHB beat path
    input  logic              ahb_req,
    input  logic              ahb_write,
    input  logic [ADDR_W-1:0] ahb_addr,
    input  logic [DATA_W-1:0] ahb_wdata,
    input  logic              ahb_burst_active,
    output logic              ahb_ready,
    output logic [DATA_W-1:0] ahb_rdata,
    output logic              ahb_rvalid,
    // Operand loader (read only)
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    // SRAM macro wrapper
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_STARVE_W = $clog2(MAX_WAIT + 1);
    localparam int c_STREAK_W = $clog2(LD_QUANTUM + 1);

    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX  = c_STARVE_W'(MAX_WAIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE  = c_STARVE_W'(1);
    localparam logic [c_STREAK_W-1:0] c_QUANTUM     = c_STREAK_W'(LD_QUANTUM);
    localparam logic [c_STREAK_W-1:0] c_STREAK_ONE  = c_STREAK_W'(1);

    // Current SRAM owner; AHB is also held here across burst BUSY cycles
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AHB  = 2'd1,
        ST_LD   = 2'd2
    } state_t;

    // Which requester the read data returning this cycle belongs to
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_AHB  = 2'd1,
        TAG_LD   = 2'd2
    } tag_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                  r_state;
    tag_t                    r_rd_tag;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    logic [c_STREAK_W-1:0]   r_ld_streak;
    logic [DATA_W-1:0]       r_ahb_rdata_q;
    logic [DATA_W-1:0]       r_ld_rdata_q;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t                  w_state_nxt;
    tag_t                    w_rd_tag_nxt;
    logic                    w_force;
    logic                    w_ahb_gnt_raw;
    logic                    w_ld_gnt_raw;
    logic                    w_ahb_gnt;
    logic                    w_ld_gnt;

    // Loader has waited its full budget: it wins over everything, even a burst
    assign w_force = ld_req && (r_starve_cnt == c_STARVE_MAX);

    // Grants are suppressed while reset is held so nothing reaches the SRAM
    assign w_ahb_gnt = w_ahb_gnt_raw & n_rst;
    assign w_ld_gnt  = w_ld_gnt_raw  & n_rst;

    assign ahb_ready = w_ahb_gnt;
    assign ld_gnt    = w_ld_gnt;

    // Owner state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant selection by current owner, then next owner from the grant
    always_comb begin
        w_ahb_gnt_raw = 1'b0;
        w_ld_gnt_raw  = 1'b0;
        w_state_nxt   = ST_IDLE;

        case (r_state)
            ST_IDLE: begin
                // Simultaneous first requests resolve to AHB
                if (ahb_req) begin
                    w_ahb_gnt_raw = 1'b1;
                end else if (ld_req) begin
                    w_ld_gnt_raw = 1'b1;
                end
            end
            ST_AHB: begin
                // A burst keeps the loader out, even during BUSY beats,
                // unless the loader has starved
                if (w_force) begin
                    w_ld_gnt_raw = 1'b1;
                end else if (ahb_req) begin
                    w_ahb_gnt_raw = 1'b1;
                end else if (!ahb_burst_active && ld_req) begin
                    w_ld_gnt_raw = 1'b1;
                end
            end
            ST_LD: begin
                // Loader keeps the port until its quantum runs out under contention
                if (ld_req && (!ahb_req || (r_ld_streak < c_QUANTUM))) begin
                    w_ld_gnt_raw = 1'b1;
                end else if (ahb_req) begin
                    w_ahb_gnt_raw = 1'b1;
                end
            end
            default: begin
                w_ahb_gnt_raw = 1'b0;
                w_ld_gnt_raw  = 1'b0;
            end
        endcase

        if (w_ahb_gnt_raw) begin
            w_state_nxt = ST_AHB;
        end else if (w_ld_gnt_raw) begin
            w_state_nxt = ST_LD;
        end else if (ahb_burst_active) begin
            w_state_nxt = ST_AHB;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Loader starvation counter: cycles spent pending without a grant
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_starve_cnt <= '0;
        end else if (!ld_req || w_ld_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + c_STARVE_ONE;
        end
    end

    // Consecutive loader grants taken while AHB was also waiting
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ld_streak <= '0;
        end else if (w_ahb_gnt || !ld_req) begin
            r_ld_streak <= '0;
        end else if (w_ld_gnt && ahb_req && (r_ld_streak != c_QUANTUM)) begin
            r_ld_streak <= r_ld_streak + c_STREAK_ONE;
        end
    end

    // SRAM drive from the winner; all zero when the port is unused
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_ahb_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = ahb_write;
            sram_addr  = ahb_addr;
            sram_wdata = ahb_wdata;
        end else if (w_ld_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = ld_addr;
        end
    end

    // Tag the owner of a read issued this cycle; writes return nothing
    always_comb begin
        w_rd_tag_nxt = TAG_NONE;
        if (w_ahb_gnt && !ahb_write) begin
            w_rd_tag_nxt = TAG_AHB;
        end else if (w_ld_gnt) begin
            w_rd_tag_nxt = TAG_LD;
        end
    end

    // Read tag register; reset drops any read that is still in flight
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rd_tag <= TAG_NONE;
        end else begin
            r_rd_tag <= w_rd_tag_nxt;
        end
    end

    // Hold the last returned word per requester so rdata is stable between reads
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ahb_rdata_q <= '0;
            r_ld_rdata_q  <= '0;
        end else begin
            if (r_rd_tag == TAG_AHB) begin
                r_ahb_rdata_q <= sram_rdata;
            end
            if (r_rd_tag == TAG_LD) begin
                r_ld_rdata_q <= sram_rdata;
            end
        end
    end

    // Read return: the tagged requester sees the SRAM word in the cycle it arrives
    assign ahb_rvalid = (r_rd_tag == TAG_AHB);
    assign ld_rvalid  = (r_rd_tag == TAG_LD);
    assign ahb_rdata  = ahb_rvalid ? sram_rdata : r_ahb_rdata_q;
    assign ld_rdata   = ld_rvalid  ? sram_rdata : r_ld_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter with a behavioural SRAM
//            and a read-return scoreboard per requester.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              ahb_req = 1'b0;
    logic              ahb_write = 1'b0;
    logic [ADDR_W-1:0] ahb_addr = '0;
    logic [DATA_W-1:0] ahb_wdata = '0;
    logic              ahb_burst_active = 1'b0;
    logic              ahb_ready;
    logic [DATA_W-1:0] ahb_rdata;
    logic              ahb_rvalid;
    logic              ld_req = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic              ld_gnt;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_rvalid;
    logic              sram_en;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata = '0;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem     [0:1023];
    logic [DATA_W-1:0] ref_mem [0:1023];
    logic [DATA_W-1:0] ahb_q [$];
    logic [DATA_W-1:0] ld_q  [$];
    logic [DATA_W-1:0] sb_exp_a;
    logic [DATA_W-1:0] sb_exp_l;

    sram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_WAIT   (8),
        .LD_QUANTUM (4)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .ahb_req          (ahb_req),
        .ahb_write        (ahb_write),
        .ahb_addr         (ahb_addr),
        .ahb_wdata        (ahb_wdata),
        .ahb_burst_active (ahb_burst_active),
        .ahb_ready        (ahb_ready),
        .ahb_rdata        (ahb_rdata),
        .ahb_rvalid       (ahb_rvalid),
        .ld_req           (ld_req),
        .ld_addr          (ld_addr),
        .ld_gnt           (ld_gnt),
        .ld_rdata         (ld_rdata),
        .ld_rvalid        (ld_rvalid),
        .sram_en          (sram_en),
        .sram_wen         (sram_wen),
        .sram_addr        (sram_addr),
        .sram_wdata       (sram_wdata),
        .sram_rdata       (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: read data appears the cycle after the access
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen) mem[sram_addr] = sram_wdata;
            else          sram_rdata <= mem[sram_addr];
        end
    end

    // Scoreboard: every rvalid must match the oldest expected read of that owner
    always @(negedge clk) begin
        if (ahb_rvalid) begin
            total++;
            if (ahb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_ahb_unexpected_rvalid got=%h exp=none", ahb_rdata);
            end else begin
                sb_exp_a = ahb_q.pop_front();
                if (ahb_rdata !== sb_exp_a) begin
                    bad++;
                    $display("FAIL sb_ahb_rdata got=%h exp=%h", ahb_rdata, sb_exp_a);
                end
            end
        end
        if (ld_rvalid) begin
            total++;
            if (ld_q.size() == 0) begin
                bad++;
                $display("FAIL sb_ld_unexpected_rvalid got=%h exp=none", ld_rdata);
            end else begin
                sb_exp_l = ld_q.pop_front();
                if (ld_rdata !== sb_exp_l) begin
                    bad++;
                    $display("FAIL sb_ld_rdata got=%h exp=%h", ld_rdata, sb_exp_l);
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] pat(input int a);
        return 64'hA5A5_0000_0000_0000 | (64'(a) << 20) | 64'(a ^ 1023);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ahb_req = 1'b0; ahb_write = 1'b0; ahb_burst_active = 1'b0; ld_req = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        ahb_req = 1'b1; ld_req = 1'b1; ahb_addr = 10'h040; ld_addr = 10'h080;
        @(negedge clk);
        total++; if (ahb_ready !== 1'b0) begin bad++; $display("FAIL rst_ahb_ready got=%b exp=0", ahb_ready); end
        total++; if (ld_gnt !== 1'b0) begin bad++; $display("FAIL rst_ld_gnt got=%b exp=0", ld_gnt); end
        total++; if (sram_en !== 1'b0) begin bad++; $display("FAIL rst_sram_en got=%b exp=0", sram_en); end
        total++; if ({ahb_rvalid, ld_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b exp=00", {ahb_rvalid, ld_rvalid}); end
        total++; if (ahb_rdata !== 64'd0) begin bad++; $display("FAIL rst_ahb_rdata got=%h exp=0", ahb_rdata); end
        total++; if (ld_rdata !== 64'd0) begin bad++; $display("FAIL rst_ld_rdata got=%h exp=0", ld_rdata); end
        idle_inputs();
        step();
        n_rst = 1'b1;
    endtask

    task automatic test_simultaneous();
        ahb_req = 1'b1; ahb_write = 1'b0; ahb_addr = 10'h040;
        ld_req = 1'b1; ld_addr = 10'h080;
        @(negedge clk);
        total++; if ({ahb_ready, ld_gnt} !== 2'b10) begin bad++; $display("FAIL sim_grant got=%b exp=10", {ahb_ready, ld_gnt}); end
        total++; if (sram_addr !== 10'h040) begin bad++; $display("FAIL sim_sram_addr got=%h exp=040", sram_addr); end
        total++; if ({sram_en, sram_wen} !== 2'b10) begin bad++; $display("FAIL sim_sram_en_wen got=%b exp=10", {sram_en, sram_wen}); end
        ahb_q.push_back(ref_mem[10'h040]);
        step();
        ahb_req = 1'b0;
        @(negedge clk);
        total++; if (ahb_rvalid !== 1'b1) begin bad++; $display("FAIL sim_ahb_rvalid got=%b exp=1", ahb_rvalid); end
        total++; if ({ahb_ready, ld_gnt} !== 2'b01) begin bad++; $display("FAIL sim_ld_grant got=%b exp=01", {ahb_ready, ld_gnt}); end
        total++; if (sram_addr !== 10'h080) begin bad++; $display("FAIL sim_ld_addr got=%h exp=080", sram_addr); end
        ld_q.push_back(ref_mem[10'h080]);
        step();
        ld_req = 1'b0;
        @(negedge clk);
        total++; if (ld_rvalid !== 1'b1) begin bad++; $display("FAIL sim_ld_rvalid got=%b exp=1", ld_rvalid); end
        step();
    endtask

    task automatic test_burst_starve();
        int  beat;
        logic exp_ld;
        beat = 0;
        ahb_burst_active = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            ahb_req = 1'b1; ahb_write = 1'b1;
            ahb_addr  = 10'h100 + 10'(beat);
            ahb_wdata = 64'hB000_0000_0000_0000 + 64'(beat);
            ld_req  = (k != 9);
            ld_addr = (k < 10) ? 10'h200 : 10'h201;
            exp_ld  = (k == 8) || (k == 18);
            @(negedge clk);
            total++; if (ld_gnt !== exp_ld) begin bad++; $display("FAIL burst_ld_gnt k=%0d got=%b exp=%b", k, ld_gnt, exp_ld); end
            total++; if (ahb_ready !== !exp_ld) begin bad++; $display("FAIL burst_ahb_ready k=%0d got=%b exp=%b", k, ahb_ready, !exp_ld); end
            if (exp_ld) begin
                ld_q.push_back(ref_mem[ld_addr]);
            end else begin
                ref_mem[ahb_addr] = ahb_wdata;
                beat++;
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_burst_busy();
        ahb_burst_active = 1'b1;
        ahb_req = 1'b1; ahb_write = 1'b1; ahb_addr = 10'h120; ahb_wdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        total++; if (ahb_ready !== 1'b1) begin bad++; $display("FAIL busy_first_beat got=%b exp=1", ahb_ready); end
        ref_mem[10'h120] = ahb_wdata;
        step();
        for (int i = 0; i < 2; i++) begin
            ahb_req = 1'b0; ld_req = 1'b1; ld_addr = 10'h210;
            @(negedge clk);
            total++; if ({ld_gnt, sram_en} !== 2'b00) begin bad++; $display("FAIL busy_ld_blocked i=%0d got=%b exp=00", i, {ld_gnt, sram_en}); end
            step();
        end
        ahb_req = 1'b1; ahb_addr = 10'h121; ahb_wdata = 64'h0FED_CBA9_8765_4321;
        @(negedge clk);
        total++; if ({ahb_ready, ld_gnt} !== 2'b10) begin bad++; $display("FAIL busy_resume got=%b exp=10", {ahb_ready, ld_gnt}); end
        ref_mem[10'h121] = ahb_wdata;
        step();
        ahb_burst_active = 1'b0; ahb_req = 1'b0;
        @(negedge clk);
        total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL busy_unlock_ld got=%b exp=1", ld_gnt); end
        ld_q.push_back(ref_mem[10'h210]);
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_ld_quantum();
        int   ld_idx;
        logic exp_ahb;
        ld_idx = 0;
        for (int c = 0; c <= 12; c++) begin
            ld_req  = 1'b1;
            ld_addr = 10'h300 + 10'(ld_idx);
            ahb_req = (c >= 2) && (c != 7);
            ahb_write = 1'b0;
            ahb_addr = (c <= 6) ? 10'h050 : 10'h051;
            exp_ahb = (c == 6) || (c == 12);
            @(negedge clk);
            total++; if (ahb_ready !== exp_ahb) begin bad++; $display("FAIL quantum_ahb c=%0d got=%b exp=%b", c, ahb_ready, exp_ahb); end
            total++; if (ld_gnt !== !exp_ahb) begin bad++; $display("FAIL quantum_ld c=%0d got=%b exp=%b", c, ld_gnt, !exp_ahb); end
            if (exp_ahb) begin
                ahb_q.push_back(ref_mem[ahb_addr]);
            end else begin
                ld_q.push_back(ref_mem[ld_addr]);
                ld_idx++;
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_interleave();
        ahb_req = 1'b1; ahb_write = 1'b1; ahb_addr = 10'h010; ahb_wdata = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        total++; if ({ahb_ready, sram_wen} !== 2'b11) begin bad++; $display("FAIL il_write got=%b exp=11", {ahb_ready, sram_wen}); end
        total++; if (sram_wdata !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL il_wdata got=%h exp=deadbeef", sram_wdata); end
        ref_mem[10'h010] = ahb_wdata;
        step();
        ahb_req = 1'b0; ahb_write = 1'b0; ld_req = 1'b1; ld_addr = 10'h010;
        @(negedge clk);
        total++; if ({ld_gnt, sram_wen} !== 2'b10) begin bad++; $display("FAIL il_ld_read got=%b exp=10", {ld_gnt, sram_wen}); end
        total++; if (sram_wdata !== 64'd0) begin bad++; $display("FAIL il_ld_wdata got=%h exp=0", sram_wdata); end
        total++; if (ahb_rvalid !== 1'b0) begin bad++; $display("FAIL il_no_ahb_rvalid got=%b exp=0", ahb_rvalid); end
        ld_q.push_back(ref_mem[10'h010]);
        step();
        ld_req = 1'b0;
        @(negedge clk);
        total++; if (ld_rvalid !== 1'b1 || ld_rdata !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL il_ld_return got=%b/%h exp=1/deadbeef", ld_rvalid, ld_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            ahb_req = (c % 2 == 0); ahb_write = 1'b0; ahb_addr = 10'h060 + 10'(c);
            ld_req  = (c % 2 == 1); ld_addr = 10'h0A0 + 10'(c);
            @(negedge clk);
            total++; if ({ahb_ready, ld_gnt} !== {ahb_req, ld_req}) begin bad++; $display("FAIL b2b_grant c=%0d got=%b exp=%b", c, {ahb_ready, ld_gnt}, {ahb_req, ld_req}); end
            if (c > 0) begin
                total++; if ({ahb_rvalid, ld_rvalid} !== {ld_req, ahb_req}) begin bad++; $display("FAIL b2b_rvalid c=%0d got=%b exp=%b", c, {ahb_rvalid, ld_rvalid}, {ld_req, ahb_req}); end
            end
            if (ahb_req) ahb_q.push_back(ref_mem[ahb_addr]);
            else         ld_q.push_back(ref_mem[ld_addr]);
            step();
        end
        idle_inputs();
        @(negedge clk);
        total++; if ({ahb_rvalid, ld_rvalid} !== 2'b01) begin bad++; $display("FAIL b2b_last_rvalid got=%b exp=01", {ahb_rvalid, ld_rvalid}); end
        step();
    endtask

    task automatic test_reset_mid_read();
        ld_req = 1'b1; ld_addr = 10'h2F0;
        @(negedge clk);
        total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL mrst_ld_gnt got=%b exp=1", ld_gnt); end
        step();
        n_rst = 1'b0;
        @(negedge clk);
        total++; if ({ld_rvalid, ld_gnt} !== 2'b00) begin bad++; $display("FAIL mrst_discard got=%b exp=00", {ld_rvalid, ld_gnt}); end
        total++; if (ld_rdata !== 64'd0) begin bad++; $display("FAIL mrst_ld_rdata got=%h exp=0", ld_rdata); end
        step();
        @(negedge clk);
        total++; if ({ld_gnt, sram_en} !== 2'b00) begin bad++; $display("FAIL mrst_held got=%b exp=00", {ld_gnt, sram_en}); end
        ld_req = 1'b0;
        step();
        n_rst = 1'b1;
        ahb_req = 1'b1; ahb_write = 1'b0; ahb_addr = 10'h040; ld_req = 1'b1; ld_addr = 10'h081;
        @(negedge clk);
        total++; if ({ahb_ready, ld_gnt, ld_rvalid} !== 3'b100) begin bad++; $display("FAIL mrst_idle_after got=%b exp=100", {ahb_ready, ld_gnt, ld_rvalid}); end
        ahb_q.push_back(ref_mem[10'h040]);
        step();
        ahb_req = 1'b0;
        @(negedge clk);
        total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL mrst_ld_after got=%b exp=1", ld_gnt); end
        ld_q.push_back(ref_mem[10'h081]);
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = pat(i);
            ref_mem[i] = pat(i);
        end
        test_reset();
        test_simultaneous();
        test_burst_starve();
        test_burst_busy();
        test_ld_quantum();
        test_interleave();
        test_back_to_back();
        test_reset_mid_read();
        idle_inputs();
        step();
        step();
        total++;
        if (ahb_q.size() != 0 || ld_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d/%0d exp=0/0", ahb_q.size(), ld_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
